// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: one-entry holding register feeding an 8N1 UART serializer.
// Game logic loads a byte with tx_send/tx_ready; the serializer shifts it out
// LSB-first and pulls the next held byte straight into a new frame with no gap.
module uart_tx_buffer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] tx_byte,
  input  logic       tx_send,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = 3;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic [7:0]          hold_q,       hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [7:0]          shift_q,      shift_d;
  logic [BAUD_W-1:0]   baud_cnt_q,   baud_cnt_d;
  logic [BIT_W-1:0]    bit_idx_q,    bit_idx_d;
  logic                ready_q,      ready_d;
  logic                serial_q,     serial_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;

  logic                bit_end_c;

  assign bit_end_c = (baud_cnt_q == BAUD_LAST);

  // Next-state logic: holding register, serializer FSM, baud/bit counters and outputs.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    baud_cnt_d   = baud_cnt_q;
    bit_idx_d    = bit_idx_q;

    // Loads only land in an empty holding register; a transfer needs it full,
    // so the two never coincide on one edge.
    if (tx_send && !hold_valid_q) begin
      hold_d       = tx_byte;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          baud_cnt_d   = '0;
          state_d      = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_cnt_d = '0;
          bit_idx_d  = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_cnt_d = '0;
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            state_d      = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next state so the registered copies line up with it.
    ready_d = ~hold_valid_d;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (baud_cnt_d == BAUD_LAST);
    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[bit_idx_d];
      default: serial_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces the line idle-high immediately.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      ready_q      <= 1'b1;
      serial_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      ready_q      <= ready_d;
      serial_q     <= serial_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tx_ready  = ready_q;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer at CLKS_PER_BIT=16 and CLKS_PER_BIT=2.
module tb_uart_tx_buffer;

  logic       clk;
  logic       nRst;
  logic [7:0] tx_byte;
  logic       send;
  logic       sel;      // 0: 16-clock instance, 1: 2-clock instance

  logic send16, ready16, ser16, busy16, done16;
  logic send2,  ready2,  ser2,  busy2,  done2;
  logic ready, ser, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = 0;

  assign send16 = send & ~sel;
  assign send2  = send & sel;
  assign ready  = sel ? ready2 : ready16;
  assign ser    = sel ? ser2   : ser16;
  assign busy   = sel ? busy2  : busy16;
  assign done   = sel ? done2  : done16;

  uart_tx_buffer #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .nRst(nRst), .tx_byte(tx_byte), .tx_send(send16),
    .tx_ready(ready16), .tx_serial(ser16), .tx_busy(busy16), .tx_done(done16)
  );

  uart_tx_buffer #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .nRst(nRst), .tx_byte(tx_byte), .tx_send(send2),
    .tx_ready(ready2), .tx_serial(ser2), .tx_busy(busy2), .tx_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb();
    return sel ? 2 : 16;
  endfunction

  // Present a byte for one clock, starting and ending on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    tx_byte = b;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
  endtask

  // Count cycles where the line is not idle (low, busy or done).
  task automatic idle_window(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ser !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Wait for a start bit, then check the full 10-bit frame cycle by cycle.
  // Returns with the current falling edge being the first cycle after the frame.
  task automatic check_frame(input string tag, input logic [7:0] b, input int exp_gap);
    int gap = 0;
    int found = 0;
    int n = cpb();
    int bad[10];
    int ndone = 0;
    int dpos = 0;
    int nbusy = 0;
    logic lvl;
    for (int i = 0; i < 40 * n; i++) begin
      if (ser === 1'b0) begin
        found = 1;
        break;
      end
      gap++;
      @(negedge clk);
    end
    check({tag, "_start"}, found, 1);
    if (exp_gap >= 0) check({tag, "_gap"}, gap, exp_gap);
    for (int k = 0; k < 10; k++) bad[k] = 0;
    for (int c = 1; c <= 10 * n; c++) begin
      int k = (c - 1) / n;
      if (k == 0)      lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else             lvl = b[k-1];
      if (ser !== lvl) bad[k]++;
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        ndone++;
        dpos = c;
        done_cyc = cyc;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) check($sformatf("%s_bit%0d", tag, k), bad[k], 0);
    check({tag, "_done_cnt"}, ndone, 1);
    check({tag, "_done_pos"}, dpos, 10 * n);
    check({tag, "_busy_cnt"}, nbusy, 10 * n);
  endtask

  initial begin
    int d1;
    int rdy_hi;
    nRst = 1'b0;
    send = 1'b0;
    tx_byte = 8'h00;
    sel = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_byte = 8'($urandom);
      send    = 1'($urandom_range(0, 1));
    end
    check("rst_serial16", ser16, 1);
    check("rst_ready16",  ready16, 1);
    check("rst_busy16",   busy16, 0);
    check("rst_done16",   done16, 0);
    check("rst_serial2",  ser2, 1);
    check("rst_ready2",   ready2, 1);
    send = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    idle_window("rst_idle", 50);

    // Single byte 0xA5
    send_byte(8'hA5);
    check_frame("a5", 8'hA5, -1);
    check("a5_post_busy", busy, 0);
    check("a5_post_ready", ready, 1);
    idle_window("a5_idle", 20);

    // Back-to-back 0x41 then 0x5A
    send_byte(8'h41);
    fork
      begin
        check_frame("b41", 8'h41, -1);
        d1 = done_cyc;
        check("b2b_ready_after_xfer", ready, 1);
        check_frame("b5a", 8'h5A, 0);
        check("b2b_done_delta", done_cyc - d1, 160);
      end
      begin
        repeat (60) @(negedge clk);
        send_byte(8'h5A);
        rdy_hi = 0;
        for (int i = 0; i < 80; i++) begin
          @(negedge clk);
          if (ready === 1'b1) rdy_hi++;
        end
        check("b2b_ready_low", rdy_hi, 0);
      end
    join
    idle_window("b2b_idle", 20);

    // Overrun: 0xFF offered while a frame is in flight and hold is full
    send_byte(8'h11);
    fork
      begin
        check_frame("o11", 8'h11, -1);
        check_frame("o22", 8'h22, 0);
        idle_window("ovr_no_third", 48);
      end
      begin
        repeat (30) @(negedge clk);
        send_byte(8'h22);
        repeat (20) @(negedge clk);
        check("ovr_ready_before", ready, 0);
        send_byte(8'hFF);
        rdy_hi = 0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (ready === 1'b1) rdy_hi++;
        end
        check("ovr_ready_low", rdy_hi, 0);
      end
    join

    // Reset during data bit 3 of 0x3C with 0x77 queued behind it
    send_byte(8'h3C);
    for (int i = 0; i < 40 && ser !== 1'b0; i++) @(negedge clk);
    check("mid_start", ser, 0);
    send_byte(8'h77);
    repeat (68) @(negedge clk);
    #1 nRst = 1'b0;
    #1;
    check("mid_rst_serial", ser, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_done", done, 0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    idle_window("mid_held_dropped", 48);
    send_byte(8'h00);
    check_frame("z00", 8'h00, -1);

    // CLKS_PER_BIT=2: 0x00 then 0xFF back-to-back
    sel = 1'b1;
    idle_window("e_idle", 5);
    send_byte(8'h00);
    fork
      begin
        check_frame("e00", 8'h00, -1);
        d1 = done_cyc;
        check_frame("eff", 8'hFF, 0);
        check("e_done_delta", done_cyc - d1, 20);
      end
      begin
        @(negedge clk);
        check("e_ready_after_xfer", ready, 1);
        send_byte(8'hFF);
      end
    join
    idle_window("e_post_idle", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound in case a wait above ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Transmit-side byte buffer and UART serializer for the game datapath. It accepts a byte from game logic through a valid/ready strobe and holds it in a one-entry holding register. It then shifts the byte out on a single serial line as an 8N1 frame (start, 8 data LSB-first, stop). It is the outbound counterpart of the receive buffer that captures UART bytes for the game, and lets game logic queue one byte while another is on the wire.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nRst  input  1  asynchronous, active-low reset.
- tx_byte  input  8  byte to transmit; sampled only on an accepting edge.
- tx_send  input  1  request to load tx_byte.
- tx_ready  output  1  holding register is empty, so a load is accepted this cycle.
- tx_serial  output  1  serial line; idle high.
- tx_busy  output  1  serializer is mid-frame.
- tx_done  output  1  one-cycle pulse marking the last cycle of a stop bit.

## Operation
- Accept:
  - A load is accepted on an edge where tx_send=1 and tx_ready=1. On that edge, hold ← tx_byte and hold_valid ← 1.
  - tx_ready = ~hold_valid.
  - tx_send while tx_ready=0 is ignored: no state change and the byte is dropped.
- Serializer FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_serial=1, tx_busy=0.
  - If hold_valid=1, the next edge does shift ← hold, hold_valid ← 0, baud_cnt ← 0, and moves to START.
- START:
  - tx_serial=0 for CLKS_PER_BIT cycles.
  - Then moves to DATA with bit_idx ← 0.
- DATA:
  - tx_serial = shift[bit_idx] for CLKS_PER_BIT cycles per bit, bit_idx 0..7.
  - After bit 7 completes, moves to STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - tx_done=1 during the final STOP cycle only.
  - At the end of STOP, if hold_valid=1, it transfers hold to shift and goes directly to START, with no idle cycle. Otherwise it goes to IDLE.
- tx_busy = (state != IDLE).
- Counters:
  - baud_cnt has width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - bit_idx is 3 bits and wraps 7→0 on the DATA→STOP transition.
- Simultaneous events: on the edge where hold transfers to shift, tx_ready is still 0 (hold_valid was 1), so no new load occurs on that edge. A new byte can be accepted on the following edge.
- tx_byte changing after the accept edge has no effect on the queued or in-flight byte.

## Timing
- Reset values (asynchronous, on nRst=0):
  - tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - hold=0, hold_valid=0, shift=0, baud_cnt=0, bit_idx=0, state=IDLE.
- Latency with the FSM in IDLE:
  - Accept edge E → transfer at E+1.
  - tx_serial falls low after E+1.
  - Start bit occupies cycles E+1 .. E+CLKS_PER_BIT.
- Frame length: exactly 10×CLKS_PER_BIT cycles from the start-bit fall to the end of stop.
- tx_done occurs in frame cycle 10×CLKS_PER_BIT (1-based).
- Back-to-back frames: the next start bit begins the cycle immediately after the last stop cycle.
- Throughput: one byte per 10×CLKS_PER_BIT cycles, sustained.
- Reset mid-frame:
  - tx_serial goes high immediately and asynchronously; the frame is aborted with no tx_done.
  - Any held byte is discarded.
  - The first frame after reset release is fully correct.

## Test plan
- Reset: hold nRst=0 with random inputs → tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0. Release, then 50 idle cycles → line stays 1.
- Single byte (CLKS_PER_BIT=16): send 0xA5 → sampled line is 0 | 1,0,1,0,0,1,0,1 | 1, each level held 16 cycles. tx_done pulses exactly once, in frame cycle 160. tx_busy is high for 160 cycles.
- Back-to-back: send 0x41, then send 0x5A while the first frame is in DATA → tx_ready=0 until the second frame starts. The 0x5A start bit directly follows the 0x41 stop with zero gap. Two tx_done pulses, 160 cycles apart.
- Overrun: with a frame in flight and hold full, send 0xFF → ignored. Only the in-flight and held bytes are transmitted, and tx_ready stays 0 throughout.
- Reset mid-frame: assert nRst during data bit 3 of 0x3C → tx_serial=1 in the same cycle and no tx_done. After release, send 0x00 → a correct all-zero frame with a high stop bit.
- Edge values (CLKS_PER_BIT=2): send 0x00 then 0xFF → each bit lasts 2 cycles and the frames are 20 cycles each, back-to-back. bit_idx wrap causes no extra or missing bit.
